// File: rtl/sdram_emu.sv
// sdram_emu - SDRAM device responder backed by an internal RAM.
// Decodes the controller's command bus, checks init order, bank state
// and tRCD, and answers READs with CAS-latency-aligned data.
//
// Ports:
//   clock, reset        device clock, async active-high reset
//   ramCe               clock enable; low ignores the command and freezes reads
//   ramCs/Ras/Cas/We    active-low command strobes
//   ramDqm, ramBA, ramA byte masks, bank, row/column/mode bits (A10 = auto/all)
//   ramDI / ramDO       write data in / read data out
//   ramOe               ramDO valid
//   ready               init sequence completed
//   refreshes           count of accepted REFRESH commands (wraps)
//   errInit/errBank/errRcd  sticky protocol violation flags
//
// state | meaning
// sPWR  | after reset, waiting for PRECHARGE with A10=1
// sPRE  | precharged, waiting for first REFRESH
// sRF1  | one REFRESH seen
// sRF2  | two REFRESHes seen, waiting for a legal LMR
// sRDY  | initialised; ACTIVE/READ/WRITE accepted

module sdram_emu #(
  parameter int MEM_AW = 14,
  parameter int TRCD   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ramCe,
  input  logic        ramCs,
  input  logic        ramRas,
  input  logic        ramCas,
  input  logic        ramWe,
  input  logic [1:0]  ramDqm,
  input  logic [1:0]  ramBA,
  input  logic [12:0] ramA,
  input  logic [15:0] ramDI,
  output logic [15:0] ramDO,
  output logic        ramOe,
  output logic        ready,
  output logic [15:0] refreshes,
  output logic        errInit,
  output logic        errBank,
  output logic        errRcd
);

  localparam int CW = (TRCD > 1) ? $clog2(TRCD) : 1;

  typedef enum logic [2:0] {sPWR, sPRE, sRF1, sRF2, sRDY} state_t;
  state_t state, state_nxt;

  logic cmd_en;
  logic is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
  logic mode_ok;

  assign cmd_en = ramCe & ~ramCs;
  assign is_act = cmd_en && ({ramRas, ramCas, ramWe} == 3'b011);
  assign is_rd  = cmd_en && ({ramRas, ramCas, ramWe} == 3'b101);
  assign is_wr  = cmd_en && ({ramRas, ramCas, ramWe} == 3'b100);
  assign is_pre = cmd_en && ({ramRas, ramCas, ramWe} == 3'b010);
  assign is_ref = cmd_en && ({ramRas, ramCas, ramWe} == 3'b001);
  assign is_lmr = cmd_en && ({ramRas, ramCas, ramWe} == 3'b000);

  assign mode_ok = ((ramA[6:4] == 3'd2) || (ramA[6:4] == 3'd3)) && (ramA[2:0] == 3'b000);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= sPWR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      sPWR:    if (is_pre && ramA[10]) state_nxt = sPRE;
      sPRE:    if (is_ref) state_nxt = sRF1;
      sRF1:    if (is_ref) state_nxt = sRF2;
      sRF2:    if (is_lmr && mode_ok) state_nxt = sRDY;
      default: state_nxt = state;
    endcase
  end

  assign ready = (state == sRDY);

  // Bank tracking, mode and error flags
  logic [3:0]           bank_open;
  logic [3:0][12:0]     bank_row;
  logic [3:0][CW-1:0]   bank_cnt;
  logic [1:0]           cl;
  logic                 rw_ok, rd_ok, wr_ok;
  logic [23:0]          full_addr;
  logic [MEM_AW-1:0]    addr;
  logic                 unused_hi;

  assign rw_ok     = (is_rd | is_wr) && ready && bank_open[ramBA];
  assign rd_ok     = rw_ok && is_rd;
  assign wr_ok     = rw_ok && is_wr;
  assign full_addr = {ramBA, bank_row[ramBA], ramA[8:0]};
  assign addr      = full_addr[MEM_AW-1:0];
  assign unused_hi = ^full_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_open <= '0;
      bank_row  <= '0;
      bank_cnt  <= '0;
      cl        <= 2'd2;
      refreshes <= '0;
      errInit   <= 1'b0;
      errBank   <= 1'b0;
      errRcd    <= 1'b0;
    end else begin
      // tRCD timers only advance on enabled cycles
      if (ramCe) begin
        for (int b = 0; b < 4; b++)
          if (bank_cnt[b] != '0) bank_cnt[b] <= bank_cnt[b] - 1'b1;
      end
      if (is_lmr) begin
        if (mode_ok) cl <= ramA[5:4];
        else         errInit <= 1'b1;
      end
      if ((is_act | is_rd | is_wr) && !ready) errInit <= 1'b1;
      if (is_act && ready) begin
        if (bank_open[ramBA]) errBank <= 1'b1;
        else begin
          bank_open[ramBA] <= 1'b1;
          bank_row[ramBA]  <= ramA;
          bank_cnt[ramBA]  <= CW'(TRCD - 1);
        end
      end
      if (is_pre) begin
        if (ramA[10]) bank_open <= '0;
        else          bank_open[ramBA] <= 1'b0;
      end
      if (is_ref) begin
        refreshes <= refreshes + 16'd1;
        if (|bank_open) errBank <= 1'b1;
      end
      if ((is_rd | is_wr) && ready) begin
        if (!bank_open[ramBA]) errBank <= 1'b1;
        else begin
          if (bank_cnt[ramBA] != '0) errRcd <= 1'b1;
          if (ramA[10]) bank_open[ramBA] <= 1'b0;
        end
      end
    end
  end

  // Memory and read-data stages; no reset so the array maps onto block RAM
  logic [15:0] mem [0:(1<<MEM_AW)-1];
  logic [15:0] s0_data, s1_data;
  logic        s0_vld, s1_vld;
  logic [1:0]  s0_dqm, s1_dqm;

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      if (!ramDqm[0]) mem[addr][7:0]  <= ramDI[7:0];
      if (!ramDqm[1]) mem[addr][15:8] <= ramDI[15:8];
    end
    if (rd_ok) s0_data <= mem[addr];
    if (ramCe) s1_data <= s0_data;
  end

  // Stage 0 is loaded at the command edge; CL3 takes one extra stage
  logic        src_vld;
  logic [1:0]  src_dqm;
  logic [15:0] src_data;

  assign src_vld  = (cl == 2'd3) ? s1_vld  : s0_vld;
  assign src_dqm  = (cl == 2'd3) ? s1_dqm  : s0_dqm;
  assign src_data = (cl == 2'd3) ? s1_data : s0_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s0_vld <= 1'b0;
      s0_dqm <= '0;
      s1_vld <= 1'b0;
      s1_dqm <= '0;
      ramOe  <= 1'b0;
      ramDO  <= '0;
    end else if (ramCe) begin
      s0_vld <= rd_ok;
      s0_dqm <= ramDqm;
      s1_vld <= s0_vld;
      s1_dqm <= s0_dqm;
      ramOe  <= src_vld;
      if (src_vld)
        ramDO <= {src_dqm[1] ? 8'h00 : src_data[15:8],
                  src_dqm[0] ? 8'h00 : src_data[7:0]};
    end
  end

endmodule

// File: tb/tb_sdram_emu.sv
module tb_sdram_emu;

  localparam int TRCD = 3;
  localparam int MEMW = 1 << 14;

  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101,
                         C_WR  = 3'b100, C_PRE = 3'b010, C_REF = 3'b001,
                         C_LMR = 3'b000;

  logic        clock = 1'b0, reset = 1'b1;
  logic        ramCe = 1'b1, ramCs = 1'b1, ramRas = 1'b1, ramCas = 1'b1, ramWe = 1'b1;
  logic [1:0]  ramDqm = '0, ramBA = '0;
  logic [12:0] ramA = '0;
  logic [15:0] ramDI = '0;
  logic [15:0] ramDO, refreshes;
  logic        ramOe, ready, errInit, errBank, errRcd;

  sdram_emu #(.MEM_AW(14), .TRCD(TRCD)) dut (
    .clock(clock), .reset(reset), .ramCe(ramCe), .ramCs(ramCs),
    .ramRas(ramRas), .ramCas(ramCas), .ramWe(ramWe), .ramDqm(ramDqm),
    .ramBA(ramBA), .ramA(ramA), .ramDI(ramDI), .ramDO(ramDO), .ramOe(ramOe),
    .ready(ready), .refreshes(refreshes), .errInit(errInit),
    .errBank(errBank), .errRcd(errRcd)
  );

  always #5 clock = ~clock;

  int tests = 0, failed = 0;

  // Reference model: init progress, sticky flags, per-bank open/row/activation
  // time, sparse memory, and a queue of expected read words by output cycle.
  typedef struct { int due; logic [15:0] d; } rd_t;
  rd_t               q[$];
  logic [15:0]       mem_m [int];
  int                cyc = 0, init_m = 0, cl_m = 2;
  logic [15:0]       refs_m = '0;
  bit                e_init = 0, e_bank = 0, e_rcd = 0;
  bit                open_m [4];
  logic [12:0]       row_m [4];
  int                act_at [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [1:0] dqm, input logic [15:0] di);
    bit          rdy;
    logic [23:0] full;
    int          addr;
    logic [15:0] v;
    rdy = (init_m == 4);
    case (c)
      C_ACT:
        if (!rdy) e_init = 1;
        else if (open_m[ba]) e_bank = 1;
        else begin open_m[ba] = 1; row_m[ba] = a; act_at[ba] = cyc; end
      C_RD, C_WR:
        if (!rdy) e_init = 1;
        else if (!open_m[ba]) e_bank = 1;
        else begin
          if (cyc - act_at[ba] < TRCD) e_rcd = 1;
          full = {ba, row_m[ba], a[8:0]};
          addr = int'(full) % MEMW;
          v = mem_m.exists(addr) ? mem_m[addr] : 16'hxxxx;
          if (c == C_WR) begin
            if (!dqm[0]) v[7:0]  = di[7:0];
            if (!dqm[1]) v[15:8] = di[15:8];
            mem_m[addr] = v;
          end else begin
            if (dqm[0]) v[7:0]  = 8'h00;
            if (dqm[1]) v[15:8] = 8'h00;
            q.push_back('{cyc + cl_m - 1, v});
          end
          if (a[10]) open_m[ba] = 0;
        end
      C_PRE: begin
        if (a[10]) begin for (int b = 0; b < 4; b++) open_m[b] = 0; end
        else open_m[ba] = 0;
        if (init_m == 0 && a[10]) init_m = 1;
      end
      C_REF: begin
        refs_m = refs_m + 16'd1;
        if (open_m[0] || open_m[1] || open_m[2] || open_m[3]) e_bank = 1;
        if (init_m == 1 || init_m == 2) init_m++;
      end
      C_LMR:
        if ((a[6:4] == 3'd2 || a[6:4] == 3'd3) && a[2:0] == 3'b000) begin
          cl_m = int'(a[6:4]);
          if (init_m == 3) init_m = 4;
        end else e_init = 1;
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    bit exp_oe;
    exp_oe = (q.size() > 0) && (q[0].due == cyc);
    chk("ramOe", {31'd0, ramOe}, {31'd0, exp_oe});
    if (exp_oe) begin
      if (!$isunknown(q[0].d)) chk("ramDO", {16'd0, ramDO}, {16'd0, q[0].d});
      void'(q.pop_front());
    end
    chk("ready", {31'd0, ready}, {31'd0, init_m == 4});
    chk("refreshes", {16'd0, refreshes}, {16'd0, refs_m});
    chk("errInit", {31'd0, errInit}, {31'd0, e_init});
    chk("errBank", {31'd0, errBank}, {31'd0, e_bank});
    chk("errRcd", {31'd0, errRcd}, {31'd0, e_rcd});
  endtask

  task automatic step(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                      input logic [1:0] dqm, input logic [15:0] di, input bit ce, input bit cs);
    {ramRas, ramCas, ramWe} = c;
    ramBA = ba; ramA = a; ramDqm = dqm; ramDI = di; ramCe = ce; ramCs = cs;
    @(posedge clock);
    cyc++;
    if (ce && !cs) model(c, ba, a, dqm, di);
    #1;
    {ramRas, ramCas, ramWe} = C_NOP;
    ramCe = 1'b1;
    check_outputs();
  endtask

  task automatic nop(); step(C_NOP, 2'd0, 13'd0, 2'd0, 16'd0, 1'b1, 1'b0); endtask
  task automatic act(input logic [1:0] b, input logic [12:0] row);
    step(C_ACT, b, row, 2'd0, 16'd0, 1'b1, 1'b0);
  endtask
  task automatic rd(input logic [1:0] b, input logic [8:0] col, input bit ap, input logic [1:0] dqm);
    step(C_RD, b, {2'b00, ap, 1'b0, col}, dqm, 16'd0, 1'b1, 1'b0);
  endtask
  task automatic wr(input logic [1:0] b, input logic [8:0] col, input bit ap,
                    input logic [1:0] dqm, input logic [15:0] d);
    step(C_WR, b, {2'b00, ap, 1'b0, col}, dqm, d, 1'b1, 1'b0);
  endtask
  task automatic pre(input logic [1:0] b, input bit all);
    step(C_PRE, b, {2'b00, all, 10'd0}, 2'd0, 16'd0, 1'b1, 1'b0);
  endtask
  task automatic refr(); step(C_REF, 2'd0, 13'd0, 2'd0, 16'd0, 1'b1, 1'b0); endtask
  task automatic lmr(input logic [12:0] m); step(C_LMR, 2'd0, m, 2'd0, 16'd0, 1'b1, 1'b0); endtask

  task automatic model_reset();
    init_m = 0; cl_m = 2; refs_m = '0;
    e_init = 0; e_bank = 0; e_rcd = 0;
    for (int b = 0; b < 4; b++) open_m[b] = 0;
    q.delete();
  endtask

  logic [8:0] cols [8];

  initial begin
    model_reset();
    // reset state
    #12;
    chk("rst_ramOe", {31'd0, ramOe}, 32'd0);
    chk("rst_ramDO", {16'd0, ramDO}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_refreshes", {16'd0, refreshes}, 32'd0);
    chk("rst_errs", {29'd0, errInit, errBank, errRcd}, 32'd0);
    #10 reset = 1'b0;

    // init sequence, CL2
    pre(2'd0, 1'b1);
    refr();
    refr();
    lmr(13'h0020);

    // directed write/read with byte masks
    act(2'd0, 13'h001);
    nop(); nop(); nop();
    wr(2'd0, 9'h005, 1'b0, 2'b00, 16'hBEEF);
    rd(2'd0, 9'h005, 1'b0, 2'b00);
    wr(2'd0, 9'h005, 1'b0, 2'b10, 16'h1234);
    rd(2'd0, 9'h005, 1'b0, 2'b00);
    rd(2'd0, 9'h005, 1'b0, 2'b01);
    nop(); nop();
    pre(2'd0, 1'b1);

    // randomized traffic per bank
    for (int b = 0; b < 4; b++) begin
      act(2'(b), 13'($urandom_range(0, 8191)));
      nop(); nop(); nop();
      for (int i = 0; i < 8; i++) begin
        cols[i] = 9'($urandom_range(0, 511));
        wr(2'(b), cols[i], 1'b0, 2'b00, 16'($urandom));
      end
      for (int i = 0; i < 40; i++) begin
        case ($urandom_range(0, 3))
          0: wr(2'(b), cols[$urandom_range(0, 7)], 1'b0, 2'($urandom), 16'($urandom));
          1, 2: rd(2'(b), cols[$urandom_range(0, 7)], 1'b0, 2'($urandom));
          default: nop();
        endcase
      end
      pre(2'(b), b[0]);
      nop(); nop();
      if (b[0]) refr();
    end

    // CL3 and a tRCD violation
    lmr(13'h0030);
    act(2'd0, 13'h001);
    rd(2'd0, 9'h005, 1'b0, 2'b00);
    nop(); nop();
    rd(2'd0, 9'h005, 1'b0, 2'b00);
    rd(2'd0, 9'h005, 1'b0, 2'b10);
    nop(); nop(); nop();
    pre(2'd0, 1'b0);

    // illegal modes leave CL3 in place
    lmr(13'h0040);
    lmr(13'h0031);
    act(2'd1, 13'h0042);
    nop(); nop(); nop();
    wr(2'd1, 9'h011, 1'b0, 2'b00, 16'hA5C3);
    rd(2'd1, 9'h011, 1'b0, 2'b00);
    nop(); nop(); nop();

    // auto-precharge then READ of the now-closed bank
    rd(2'd1, 9'h011, 1'b1, 2'b00);
    rd(2'd1, 9'h011, 1'b0, 2'b00);
    nop(); nop(); nop();

    // READ to a closed bank, double ACTIVE, REFRESH with a bank open
    rd(2'd2, 9'h000, 1'b0, 2'b00);
    act(2'd2, 13'h0003);
    act(2'd2, 13'h0004);
    refr();
    pre(2'd0, 1'b1);

    // reset with a CL3 read about to be sampled
    act(2'd3, 13'h0007);
    nop(); nop(); nop();
    wr(2'd3, 9'h009, 1'b0, 2'b00, 16'h5A5A);
    rd(2'd3, 9'h009, 1'b0, 2'b00);
    nop();
    nop();
    chk("midread_oe_before", {31'd0, ramOe}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midread_oe", {31'd0, ramOe}, 32'd0);
    chk("midread_ready", {31'd0, ready}, 32'd0);
    chk("midread_do", {16'd0, ramDO}, 32'd0);
    chk("midread_refreshes", {16'd0, refreshes}, 32'd0);
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;

    // ignored commands, then ACTIVE before init
    step(C_PRE, 2'd0, 13'h0400, 2'd0, 16'd0, 1'b0, 1'b0);
    step(C_PRE, 2'd0, 13'h0400, 2'd0, 16'd0, 1'b1, 1'b1);
    refr();
    act(2'd0, 13'h0001);
    nop();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
